// File: rtl/join_collector.sv
// join_collector: fires one launch pulse to all workers, collects completion pulses and
// signals the join point (wait-all / wait-any / no-wait). Watchdog built only with JOIN_TIMEOUT_EN.
module join_collector #(
  parameter int N_WORKERS = 2,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  output logic [N_WORKERS-1:0]         worker_start,
  input  logic [N_WORKERS-1:0]         worker_done,
  output logic                         busy,
  output logic                         joined,
  output logic [N_WORKERS-1:0]         done_mask,
  output logic [$clog2(N_WORKERS)-1:0] first_id,
  output logic [CNT_W-1:0]             elapsed,
  output logic                         timeout
);

  localparam int ID_W = $clog2(N_WORKERS);

  generate
    if (N_WORKERS < 2 || N_WORKERS > 16 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
      $error("join_collector: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t                 state, state_nx;
  logic [1:0]             mode_q, mode_nx;
  logic                   reached, reached_nx;
  logic [N_WORKERS-1:0]   start_nx, mask_nx;
  logic                   busy_nx, joined_nx;
  logic [ID_W-1:0]        first_nx, low_idx;
  logic [CNT_W-1:0]       elapsed_nx;

`ifdef JOIN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd, wd_nx;
  logic            timeout_nx;
`endif

  // lowest-index completion seen on this edge
  always_comb begin
    low_idx = '0;
    for (int i = N_WORKERS - 1; i >= 0; i--) begin
      if (worker_done[i]) low_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_nx   = state;
    mode_nx    = mode_q;
    reached_nx = reached;
    start_nx   = '0;
    busy_nx    = busy;
    joined_nx  = 1'b0;
    mask_nx    = done_mask;
    first_nx   = first_id;
    elapsed_nx = elapsed;
`ifdef JOIN_TIMEOUT_EN
    wd_nx      = wd;
    timeout_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = LAUNCH;
          mode_nx    = mode;
          mask_nx    = '0;
          first_nx   = '0;
          elapsed_nx = '0;
          busy_nx    = 1'b1;
          start_nx   = '1;
          // no-wait joins alongside the launch pulse itself
          reached_nx = (mode == 2'b10);
          joined_nx  = (mode == 2'b10);
`ifdef JOIN_TIMEOUT_EN
          wd_nx      = '0;
`endif
        end
      end
      LAUNCH: state_nx = WAIT;
      WAIT: begin
        mask_nx = done_mask | worker_done;
        if (done_mask == '0 && worker_done != '0) first_nx = low_idx;
        if (!reached && elapsed != '1) elapsed_nx = elapsed + CNT_W'(1);
        if (!reached && ((mode_q == 2'b01 && worker_done != '0) ||
                         (mode_q != 2'b01 && &mask_nx))) begin
          reached_nx = 1'b1;
          joined_nx  = 1'b1;
        end
        if (&mask_nx) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
`ifdef JOIN_TIMEOUT_EN
        // counts WAIT edges independently of elapsed, which freezes at the join point
        wd_nx = wd + WD_W'(1);
        if (wd_nx == WD_W'(TIMEOUT) && !(&mask_nx)) begin
          timeout_nx = 1'b1;
          state_nx   = IDLE;
          busy_nx    = 1'b0;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= 2'b00;
      reached      <= 1'b0;
      worker_start <= '0;
      busy         <= 1'b0;
      joined       <= 1'b0;
      done_mask    <= '0;
      first_id     <= '0;
      elapsed      <= '0;
    end else begin
      state        <= state_nx;
      mode_q       <= mode_nx;
      reached      <= reached_nx;
      worker_start <= start_nx;
      busy         <= busy_nx;
      joined       <= joined_nx;
      done_mask    <= mask_nx;
      first_id     <= first_nx;
      elapsed      <= elapsed_nx;
    end
  end

`ifdef JOIN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      wd      <= wd_nx;
      timeout <= timeout_nx;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
